// File: rtl/uart_fifo_pkg.sv
// Shared register map, bit positions and CTRL layout for the FIFO-backed UART mapper.
package uart_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_RX_OVERRUN   = 2;
  localparam int ST_TX_BUSY      = 3;
  localparam int ST_IRQ          = 4;
  localparam int ST_TX_OVERRUN   = 5;

  localparam int CTRL_RX_IRQ_EN  = 0;
  localparam int CTRL_TX_IRQ_EN  = 1;
  localparam int CTRL_OVR_IRQ_EN = 2;

  // Member order puts rx_irq_en at bit 0.
  typedef struct packed {
    logic ovr_irq_en;
    logic tx_irq_en;
    logic rx_irq_en;
  } ctrl_t;

  function automatic logic [7:0] ctrl_to_byte(ctrl_t c);
    return {5'b0, c};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; push and pop may coincide even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_eff, pop_eff;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign dout     = mem[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A full push+pop overwrites the slot being read; the old head is sampled before this edge.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_fifo_mapper.sv
// 6502-bus UART peripheral: RX FIFO, TX holding register, status/control/threshold and level irq.
module uart_fifo_mapper
  import uart_fifo_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter logic [7:0] CTRL_RESET = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_ready,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          rd_acc, wr_acc, rx_pop, rx_push;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  logic [7:0]    rdata_q, rdata_d;
  logic          irq_q, irq_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_valid_q, tx_valid_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          tx_ovr_q, tx_ovr_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [CW-1:0] thresh_q, thresh_d;

  logic [8:0]    count_ext, wdata_ext;
  logic [7:0]    count_sat, status_byte;
  logic          tx_wr, tx_load;

  assign rd_acc  = cs & ~we;
  assign wr_acc  = cs & we;
  assign rx_pop  = rd_acc & (addr == REG_DATA) & ~fifo_empty;
  assign rx_push = rx_byte_ready & (~fifo_full | rx_pop);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_byte),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign count_ext   = 9'(fifo_count);
  assign count_sat   = (count_ext > 9'd255) ? 8'hFF : count_ext[7:0];
  assign wdata_ext   = {1'b0, wdata};
  assign status_byte = {2'b00, tx_ovr_q, irq_q, tx_valid_q, rx_ovr_q, fifo_full, ~fifo_empty};
  assign tx_wr       = wr_acc & (addr == REG_DATA);
  assign tx_load     = tx_wr & (~tx_valid_q | tx_ready);

  always_comb begin
    rdata_d    = rdata_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    ctrl_d     = ctrl_q;
    thresh_d   = thresh_q;

    if (rd_acc) begin
      case (addr)
        REG_DATA:   rdata_d = fifo_empty ? 8'h00 : fifo_dout;
        REG_STATUS: rdata_d = status_byte;
        REG_CTRL:   rdata_d = ctrl_to_byte(ctrl_q);
        default:    rdata_d = count_sat;
      endcase
    end

    if (tx_load) begin
      tx_byte_d  = wdata;
      tx_valid_d = 1'b1;
    end else if (tx_valid_q & tx_ready) begin
      tx_valid_d = 1'b0;
    end

    if (wr_acc && addr == REG_CTRL) ctrl_d = ctrl_t'(wdata[2:0]);

    if (wr_acc && addr == REG_COUNT) begin
      if (wdata == 8'h00)              thresh_d = CW'(1);
      else if (wdata_ext > 9'(DEPTH))  thresh_d = CW'(DEPTH);
      else                             thresh_d = CW'(wdata_ext);
    end

    // Sticky flags: a new event in the same cycle beats a W1C.
    rx_ovr_d = (rx_byte_ready & fifo_full & ~rx_pop) |
               (rx_ovr_q & ~(wr_acc & (addr == REG_STATUS) & wdata[ST_RX_OVERRUN]));
    tx_ovr_d = (tx_wr & tx_valid_q & ~tx_ready) |
               (tx_ovr_q & ~(wr_acc & (addr == REG_STATUS) & wdata[ST_TX_OVERRUN]));

    irq_d = (ctrl_q.rx_irq_en  & (fifo_count >= thresh_q)) |
            (ctrl_q.tx_irq_en  & ~tx_valid_q) |
            (ctrl_q.ovr_irq_en & (rx_ovr_q | tx_ovr_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q    <= 8'h00;
      irq_q      <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_ovr_q   <= 1'b0;
      ctrl_q     <= ctrl_t'(CTRL_RESET[2:0]);
      thresh_q   <= CW'(1);
    end else begin
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_ovr_q   <= tx_ovr_d;
      ctrl_q     <= ctrl_d;
      thresh_q   <= thresh_d;
    end
  end

  assign rdata    = rdata_q;
  assign irq      = irq_q;
  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_uart_fifo_mapper.sv
// Directed bench for uart_fifo_mapper with a queue scoreboard for register reads.
module tb_uart_fifo_mapper;
  import uart_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic       clk, rst_n, cs, we, rx_byte_ready, tx_ready;
  logic [1:0] addr;
  logic [7:0] wdata, rdata, rx_byte, tx_byte;
  logic       irq, tx_valid;

  int n_pass = 0;
  int n_checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model[$];

  uart_fifo_mapper #(.DEPTH(DEPTH), .CTRL_RESET(8'h01)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cs            (cs),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .irq           (irq),
    .rx_byte       (rx_byte),
    .rx_byte_ready (rx_byte_ready),
    .tx_byte       (tx_byte),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string tag);
    cs = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(e);
    tick();
    cs = 1'b0;
    check(tag, rdata, exp_q.pop_front());
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    rx_byte = b; rx_byte_ready = 1'b1;
    tick();
    rx_byte_ready = 1'b0;
    if (model.size() < DEPTH) model.push_back(b);
  endtask

  task automatic rd_data(input string tag);
    logic [7:0] e;
    e = (model.size() == 0) ? 8'h00 : model.pop_front();
    rd(REG_DATA, e, tag);
  endtask

  task automatic push_and_read(input logic [7:0] b, input string tag);
    logic [7:0] e;
    e = (model.size() == 0) ? 8'h00 : model.pop_front();
    model.push_back(b);
    exp_q.push_back(e);
    rx_byte = b; rx_byte_ready = 1'b1;
    cs = 1'b1; we = 1'b0; addr = REG_DATA;
    tick();
    rx_byte_ready = 1'b0; cs = 1'b0;
    check(tag, rdata, exp_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'h00;
    rx_byte = 8'h00; rx_byte_ready = 1'b0; tx_ready = 1'b0;
    repeat (2) tick();
    check("reset_rdata", rdata, 8'h00);
    check("reset_irq", irq, 1'b0);
    check("reset_tx_valid", tx_valid, 1'b0);
    check("reset_tx_byte", tx_byte, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 1: basic receive and empty read
    push(8'h41); push(8'h42); push(8'h43);
    rd_data("t1_rd0"); rd_data("t1_rd1"); rd_data("t1_rd2");
    rd_data("t1_rd_empty");
    rd(REG_STATUS, 8'h00, "t1_status");

    // 2: overflow with irq masked
    wr(REG_CTRL, 8'h00);
    for (int i = 0; i < DEPTH + 1; i++) push(8'h80 + 8'(i));
    rd(REG_STATUS, 8'h07, "t2_status_full_ovr");
    rd(REG_COUNT, 8'd16, "t2_count");
    for (int i = 0; i < DEPTH; i++) rd_data("t2_drain");
    rd(REG_DATA, 8'h00, "t2_17th_absent");
    wr(REG_STATUS, 8'h04);
    rd(REG_STATUS, 8'h00, "t2_status_w1c");

    // 3: push+pop while full, then wrap across the pointer boundary
    for (int i = 0; i < DEPTH; i++) push(8'hC0 + 8'(i));
    push_and_read(8'hEE, "t3_full_pushpop");
    rd(REG_COUNT, 8'd16, "t3_count");
    rd(REG_STATUS, 8'h03, "t3_status_no_ovr");
    for (int i = 0; i < DEPTH; i++) rd_data("t3_drain");
    for (int i = 0; i < 40; i++) begin
      push(8'(i * 7 + 3));
      if (i % 3 != 0) rd_data("t3_wrap");
    end
    while (model.size() != 0) rd_data("t3_wrap_tail");
    rd(REG_COUNT, 8'd0, "t3_count_empty");

    // 4: threshold interrupt and clamping
    wr(REG_CTRL, 8'h01);
    wr(REG_COUNT, 8'd4);
    push(8'h01); push(8'h02); push(8'h03);
    tick();
    check("t4_irq_below", irq, 1'b0);
    push(8'h04);
    check("t4_irq_latency", irq, 1'b0);
    tick();
    check("t4_irq_at_thresh", irq, 1'b1);
    rd_data("t4_pop");
    check("t4_irq_after_pop_edge", irq, 1'b1);
    tick();
    check("t4_irq_cleared", irq, 1'b0);
    wr(REG_COUNT, 8'd0);
    tick();
    check("t4_thresh0_is_1", irq, 1'b1);
    wr(REG_COUNT, 8'd200);
    tick();
    check("t4_thresh_clamped", irq, 1'b0);
    while (model.size() != 0) rd_data("t4_drain");

    // 5: TX holding register
    wr(REG_CTRL, 8'h00);
    tx_ready = 1'b0;
    wr(REG_DATA, 8'h55);
    check("t5_tx_valid", tx_valid, 1'b1);
    check("t5_tx_byte", tx_byte, 8'h55);
    wr(REG_DATA, 8'h66);
    check("t5_tx_byte_stable", tx_byte, 8'h55);
    rd(REG_STATUS, 8'h28, "t5_status_tx_ovr");
    tx_ready = 1'b1;
    wr(REG_DATA, 8'h77);
    check("t5_tx_reload_byte", tx_byte, 8'h77);
    check("t5_tx_reload_valid", tx_valid, 1'b1);
    tick();
    check("t5_tx_done", tx_valid, 1'b0);
    tx_ready = 1'b0;
    wr(REG_CTRL, 8'h02);
    check("t5_irq_latency", irq, 1'b0);
    rd(REG_CTRL, 8'h02, "t5_ctrl");
    check("t5_irq_tx_idle", irq, 1'b1);
    wr(REG_STATUS, 8'h20);
    rd(REG_STATUS, 8'h10, "t5_status_w1c_tx");

    // 6: asynchronous reset mid-transfer
    wr(REG_COUNT, 8'd1);
    wr(REG_CTRL, 8'h05);
    for (int i = 0; i < DEPTH / 2; i++) push(8'h10 + 8'(i));
    wr(REG_DATA, 8'h99);
    check("t6_pre_tx_valid", tx_valid, 1'b1);
    rd(REG_COUNT, 8'd8, "t6_pre_count");
    check("t6_pre_irq", irq, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_rdata", rdata, 8'h00);
    check("t6_async_irq", irq, 1'b0);
    check("t6_async_tx_valid", tx_valid, 1'b0);
    check("t6_async_tx_byte", tx_byte, 8'h00);
    model.delete();
    @(negedge clk); rst_n = 1'b1;
    tick();
    rd(REG_COUNT, 8'd0, "t6_count_after");
    rd(REG_CTRL, 8'h01, "t6_ctrl_after");
    rd(REG_STATUS, 8'h00, "t6_status_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
